// File: rtl/core_pkg.sv
// Shared encodings for the rv32_core_ws core: opcodes, funct3 values,
// FSM state type and byte-enable patterns.
package core_pkg;

    // Major opcodes
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BCC   = 7'b1100011;
    localparam logic [6:0] OP_LCC   = 7'b0000011;
    localparam logic [6:0] OP_SCC   = 7'b0100011;
    localparam logic [6:0] OP_MCC   = 7'b0010011;
    localparam logic [6:0] OP_RCC   = 7'b0110011;
    localparam logic [6:0] OP_MAC   = 7'b1111111;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Load / store funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // ALU funct3
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Core FSM
    typedef enum logic {
        EXEC = 1'b0,
        MEMW = 1'b1
    } state_e;

    // Byte-enable patterns
    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H1 = 4'b1100;
    localparam logic [3:0] BE_W  = 4'b1111;

    // Byte enables for an access of the given size at the given offset;
    // misaligned halves/words fall back to the aligned pattern.
    function automatic logic [3:0] be_pattern(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = BE_B0 << off;
            2'b01:   be = off[1] ? BE_H1 : BE_H0;
            default: be = BE_W;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/core_alu.sv
// Combinational ALU for rv32_core_ws: arithmetic/logic result plus the
// branch-taken compare for conditional branches.
module core_alu
    import core_pkg::*;
(
    input  logic [2:0]  fct3,
    input  logic        fct7_5,
    input  logic        is_rtype,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        br_taken
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    // ALU result; SUB only for register-register ops, SRA sign-fills
    always_comb begin
        result = '0;
        case (fct3)
            F3_ADD:  result = (is_rtype && fct7_5) ? a - b : a + b;
            F3_SLL:  result = a << shamt;
            F3_SLT:  result = {31'd0, $signed(a) < $signed(b)};
            F3_SLTU: result = {31'd0, a < b};
            F3_XOR:  result = a ^ b;
            F3_SR:   result = fct7_5 ? $unsigned($signed(a) >>> shamt) : a >> shamt;
            F3_OR:   result = a | b;
            F3_AND:  result = a & b;
            default: result = '0;
        endcase
    end

    // Branch condition; BGE/BGEU are greater-or-equal
    always_comb begin
        br_taken = 1'b0;
        case (fct3)
            F3_BEQ:  br_taken = (a == b);
            F3_BNE:  br_taken = (a != b);
            F3_BLT:  br_taken = ($signed(a) <  $signed(b));
            F3_BGE:  br_taken = ($signed(a) >= $signed(b));
            F3_BLTU: br_taken = (a <  b);
            F3_BGEU: br_taken = (a >= b);
            default: br_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv32_core_ws.sv
// rv32_core_ws: 2-stage RV32I/RV32E core (fetch + execute/writeback) with a
// data-bus wait-state handshake. Optional MAC instruction enabled by the
// CORE_MAC_EN macro (opcode 7'b1111111 is a NOP when it is not defined).
module rv32_core_ws
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] RESET_SP = 32'd8192,
    parameter int          NREGS    = 32
) (
    input  logic        clk,
    input  logic        res,
    input  logic        halt,
    input  logic [31:0] in_data,
    output logic [31:0] in_addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic [31:0] address,
    output logic        write_e,
    output logic        read_e,
    output logic [3:0]  BE,
    input  logic        data_rdy
);

    localparam int RW = $clog2(NREGS);

    if (NREGS != 32 && NREGS != 16) begin : g_nregs_check
        $error("rv32_core_ws: NREGS must be 16 or 32");
    end

    logic [31:0] pc_q, pc_d, nxpc_q, nxpc_d;
    logic        flush_q, flush_d, hold_q, hold_d;
    logic [31:0] ir_q, ir_d;
    state_e      state_q, state_d;
    logic [31:0] regs_q [NREGS];

    // The fetched word must be kept locally whenever the pipeline stalls,
    // because the ROM keeps returning the word at in_addr (the next one).
    logic [31:0] inst;
    assign inst = hold_q ? ir_q : in_data;

    logic [6:0] opcode;
    logic [4:0] rd_idx, rs1_idx, rs2_idx;
    logic [2:0] fct3;
    assign opcode  = inst[6:0];
    assign rd_idx  = inst[11:7];
    assign fct3    = inst[14:12];
    assign rs1_idx = inst[19:15];
    assign rs2_idx = inst[24:20];

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'd0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    logic valid;
    logic is_lui, is_auipc, is_jal, is_jalr, is_bcc, is_load, is_store, is_mcc, is_rcc, is_mac;
    assign valid    = !flush_q;
    assign is_lui   = valid && (opcode == OP_LUI);
    assign is_auipc = valid && (opcode == OP_AUIPC);
    assign is_jal   = valid && (opcode == OP_JAL);
    assign is_jalr  = valid && (opcode == OP_JALR);
    assign is_bcc   = valid && (opcode == OP_BCC);
    assign is_load  = valid && (opcode == OP_LCC);
    assign is_store = valid && (opcode == OP_SCC);
    assign is_mcc   = valid && (opcode == OP_MCC);
    assign is_rcc   = valid && (opcode == OP_RCC);
`ifdef CORE_MAC_EN
    assign is_mac   = valid && (opcode == OP_MAC);
`else
    assign is_mac   = 1'b0;
`endif

    // Register reads; x0 and indices beyond the file read as zero
    logic [31:0] rs1_v, rs2_v;
    assign rs1_v = (rs1_idx != 5'd0 && int'(rs1_idx) < NREGS) ? regs_q[rs1_idx[RW-1:0]] : '0;
    assign rs2_v = (rs2_idx != 5'd0 && int'(rs2_idx) < NREGS) ? regs_q[rs2_idx[RW-1:0]] : '0;

    logic [31:0] mac_v;
`ifdef CORE_MAC_EN
    logic [31:0] rd_v;
    assign rd_v  = (rd_idx != 5'd0 && int'(rd_idx) < NREGS) ? regs_q[rd_idx[RW-1:0]] : '0;
    assign mac_v = rd_v + rs1_v * rs2_v;
`else
    assign mac_v = '0;
`endif

    logic [31:0] alu_b, alu_res;
    logic        br_taken;
    assign alu_b = (opcode == OP_RCC || opcode == OP_BCC) ? rs2_v : imm_i;

    core_alu u_alu (
        .fct3     (fct3),
        .fct7_5   (inst[30]),
        .is_rtype (opcode == OP_RCC),
        .a        (rs1_v),
        .b        (alu_b),
        .result   (alu_res),
        .br_taken (br_taken)
    );

    // Data-bus address, byte enables and store lane placement
    logic mem_op;
    assign mem_op  = is_load || is_store;
    assign address = rs1_v + ((opcode == OP_SCC) ? imm_s : imm_i);
    assign read_e  = !res && is_load;
    assign write_e = !res && is_store;

    always_comb begin
        BE       = be_pattern(fct3[1:0], address[1:0]);
        data_out = rs2_v;
        case (fct3[1:0])
            2'b00:   data_out = {4{rs2_v[7:0]}};
            2'b01:   data_out = {2{rs2_v[15:0]}};
            default: data_out = rs2_v;
        endcase
        data_out = data_out & {{8{BE[3]}}, {8{BE[2]}}, {8{BE[1]}}, {8{BE[0]}}};
    end

    // Load lane extraction with sign/zero extension
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_v;
    always_comb begin
        lane_b = 8'(data_in >> {address[1:0], 3'b000});
        lane_h = 16'(data_in >> {address[1], 4'b0000});
        case (fct3)
            F3_LB:   load_v = {{24{lane_b[7]}}, lane_b};
            F3_LH:   load_v = {{16{lane_h[15]}}, lane_h};
            F3_LBU:  load_v = {24'd0, lane_b};
            F3_LHU:  load_v = {16'd0, lane_h};
            default: load_v = data_in;
        endcase
    end

    // Control transfer: taken jump/branch redirects NXPC and squashes one slot
    logic        taken, advance;
    logic [31:0] target;
    assign taken   = is_jal || is_jalr || (is_bcc && br_taken);
    assign advance = !halt && (!mem_op || data_rdy);

    always_comb begin
        target = pc_q + imm_b;
        if (is_jal)  target = pc_q + imm_j;
        if (is_jalr) target = (rs1_v + imm_i) & ~32'd1;
    end

    // Writeback select and enable; writes to x0 or beyond the file are dropped
    logic        wb_en;
    logic [31:0] wb_data;
    always_comb begin
        wb_data = alu_res;
        if (is_lui)            wb_data = imm_u;
        if (is_auipc)          wb_data = pc_q + imm_u;
        if (is_jal || is_jalr) wb_data = pc_q + 32'd4;
        if (is_load)           wb_data = load_v;
        if (is_mac)            wb_data = mac_v;
        wb_en = advance && rd_idx != 5'd0 && int'(rd_idx) < NREGS &&
                (is_lui || is_auipc || is_jal || is_jalr || is_load || is_mcc || is_rcc || is_mac);
    end

    // Next PC / fetch / flush / hold state
    always_comb begin
        pc_d    = pc_q;
        nxpc_d  = nxpc_q;
        flush_d = flush_q;
        hold_d  = 1'b1;
        ir_d    = inst;
        if (advance) begin
            pc_d    = nxpc_q;
            nxpc_d  = taken ? target : nxpc_q + 32'd4;
            flush_d = taken;
            hold_d  = 1'b0;
        end
    end

    // FSM next state: wait in MEMW until the bus acknowledges
    always_comb begin
        state_d = state_q;
        case (state_q)
            EXEC:    if (!halt && mem_op && !data_rdy) state_d = MEMW;
            MEMW:    if (!halt && data_rdy) state_d = EXEC;
            default: state_d = EXEC;
        endcase
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (res) begin
            pc_q    <= RESET_PC;
            nxpc_q  <= RESET_PC;
            flush_q <= 1'b1;
            hold_q  <= 1'b0;
            state_q <= EXEC;
        end else begin
            pc_q    <= pc_d;
            nxpc_q  <= nxpc_d;
            flush_q <= flush_d;
            hold_q  <= hold_d;
            state_q <= state_d;
        end
    end

    // Held instruction word
    always_ff @(posedge clk) begin
        ir_q <= ir_d;
    end

    // Register file; only the stack pointer has a reset value
    always_ff @(posedge clk) begin
        if (res) begin
            regs_q[2] <= RESET_SP;
        end else if (wb_en) begin
            regs_q[rd_idx[RW-1:0]] <= wb_data;
        end
    end

    assign in_addr = res ? RESET_PC : nxpc_q;

endmodule

// File: tb/tb_rv32_core_ws.sv
// Testbench for rv32_core_ws (RESET_PC=0x100, NREGS=16). A program in a
// synchronous ROM model exercises reset, wait-state load, byte/half lanes,
// BGE/BGEU flush, SRAI, RV32E index limits, halt and MAC (CORE_MAC_EN aware).
module tb_rv32_core_ws;

    logic        clk = 1'b0;
    logic        res, halt, data_rdy, write_e, read_e;
    logic [31:0] in_data = '0;
    logic [31:0] in_addr, data_in, data_out, address;
    logic [3:0]  BE;

    always #5 clk = ~clk;

    rv32_core_ws #(.RESET_PC(32'h100), .RESET_SP(32'd8192), .NREGS(16)) dut (
        .clk(clk), .res(res), .halt(halt), .in_data(in_data), .in_addr(in_addr),
        .data_in(data_in), .data_out(data_out), .address(address), .write_e(write_e),
        .read_e(read_e), .BE(BE), .data_rdy(data_rdy)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] rom [256];
    int          n_cmp = 0, n_err = 0;
    int          rom_i = 64;
    int          txn_n = 0, lw_cycles = 0, wait_left = 0;
    bit          busy = 0;
    logic [31:0] acc_in_addr;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Instruction encoders
    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [2:0] f3, input logic [4:0] rs1, input logic [31:0] im);
        return {im[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [31:0] im);
        return {im[11:5], rs2, rs1, f3, im[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [31:0] im);
        return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] f7);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [31:0] im);
        return {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:2] == 30'h80) return 32'hCAFE_1234;
        if (a[31:2] == 30'h81) return 32'h1234_80FF;
        return 32'h0;
    endfunction

    task automatic put(input logic [31:0] ins);
        rom[rom_i] = ins;
        rom_i++;
    endtask

    task automatic expect_txn(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.be = be; t.data = d;
        exp_q.push_back(t);
    endtask

    // Synchronous ROM: word for in_addr is presented the following cycle
    always @(posedge clk) in_data <= rom[in_addr[9:2]];

    // Bus model and scoreboard pop; 3 wait cycles on the word at 0x200
    always @(negedge clk) begin
        if (!res && !halt) begin
            if (read_e || write_e) begin
                if (!busy) begin
                    busy = 1;
                    acc_in_addr = in_addr;
                    wait_left = (read_e && address == 32'h200) ? 3 : 0;
                    if (exp_q.size() == 0) begin
                        check_val($sformatf("extra_txn_at_%h", address), 32'd1, 32'd0);
                    end else begin
                        txn_t t;
                        t = exp_q.pop_front();
                        check_val($sformatf("txn%0d_we", txn_n), {31'd0, write_e}, {31'd0, t.we});
                        check_val($sformatf("txn%0d_addr", txn_n), address, t.addr);
                        check_val($sformatf("txn%0d_be", txn_n), {28'd0, BE}, {28'd0, t.be});
                        if (t.we) check_val($sformatf("txn%0d_data", txn_n), data_out, t.data);
                    end
                    txn_n++;
                end else if (read_e && address == 32'h200) begin
                    check_val("lw_wait_in_addr", in_addr, acc_in_addr);
                end
                if (read_e && address == 32'h200) lw_cycles++;
                data_in = mem_word(address);
                if (wait_left > 0) begin
                    data_rdy = 1'b0;
                    wait_left--;
                end else begin
                    data_rdy = 1'b1;
                    busy = 0;
                end
            end else begin
                data_rdy = 1'b1;
            end
        end
    end

    initial begin
        bit found;
        res = 1'b1; halt = 1'b0; data_rdy = 1'b1; data_in = '0;
        for (int i = 0; i < 256; i++) rom[i] = 32'h0;

        put(enc_i(7'b0010011, 5, 3'b000, 2, 0));            // ADDI x5,x2,0
        put(enc_s(3'b010, 0, 5, 0));                         // SW x5,0(x0)
        expect_txn(1, 32'h0, 4'b1111, 32'd8192);
        put(enc_i(7'b0010011, 1, 3'b000, 0, 32'h200));      // ADDI x1,x0,0x200
        put(enc_i(7'b0000011, 6, 3'b010, 1, 0));            // LW x6,0(x1)
        expect_txn(0, 32'h200, 4'b1111, 0);
        put(enc_s(3'b010, 0, 6, 4));                         // SW x6,4(x0)
        expect_txn(1, 32'h4, 4'b1111, 32'hCAFE_1234);
        put(enc_i(7'b0000011, 10, 3'b000, 1, 5));           // LB x10,5(x1)
        expect_txn(0, 32'h205, 4'b0010, 0);
        put(enc_i(7'b0000011, 11, 3'b101, 1, 6));           // LHU x11,6(x1)
        expect_txn(0, 32'h206, 4'b1100, 0);
        put(enc_s(3'b010, 0, 10, 28));                       // SW x10,28(x0)
        expect_txn(1, 32'd28, 4'b1111, 32'hFFFF_FF80);
        put(enc_s(3'b010, 0, 11, 32));                       // SW x11,32(x0)
        expect_txn(1, 32'd32, 4'b1111, 32'h0000_1234);
        put(enc_i(7'b0010011, 7, 3'b000, 0, 32'hAB));       // ADDI x7,x0,0xAB
        put(enc_s(3'b000, 0, 7, 3));                         // SB x7,3(x0)
        expect_txn(1, 32'h3, 4'b1000, 32'hAB00_0000);
        put(enc_i(7'b0010011, 1, 3'b000, 0, -32'sd5));      // ADDI x1,x0,-5
        put(enc_i(7'b0010011, 2, 3'b000, 0, -32'sd5));      // ADDI x2,x0,-5
        put(enc_b(3'b101, 1, 2, 8));                         // BGE x1,x2,+8
        put(enc_s(3'b010, 0, 1, 8));                         // SW x1,8(x0)   squashed
        put(enc_i(7'b0010011, 3, 3'b000, 0, -32'sd1));      // ADDI x3,x0,-1
        put(enc_i(7'b0010011, 4, 3'b000, 0, 1));            // ADDI x4,x0,1
        put(enc_b(3'b111, 3, 4, 8));                         // BGEU x3,x4,+8
        put(enc_s(3'b010, 0, 3, 12));                        // SW x3,12(x0)  squashed
        put({20'h80000, 5'd4, 7'b0110111});                  // LUI x4,0x80000
        put(enc_i(7'b0010011, 3, 3'b101, 4, 32'h404));      // SRAI x3,x4,4
        put(enc_s(3'b010, 0, 3, 16));                        // SW x3,16(x0)
        expect_txn(1, 32'd16, 4'b1111, 32'hF800_0000);
        put(enc_i(7'b0010011, 20, 3'b000, 0, 1));           // ADDI x20,x0,1 (dropped)
        put(enc_r(7'b0110011, 9, 3'b000, 20, 0, 7'd0));     // ADD x9,x20,x0
        put(enc_s(3'b010, 0, 9, 20));                        // SW x9,20(x0)
        expect_txn(1, 32'd20, 4'b1111, 32'h0);
        put(enc_s(3'b010, 0, 4, 36));                        // SW x4,36(x0)
        expect_txn(1, 32'd36, 4'b1111, 32'h8000_0000);
        put(enc_i(7'b0010011, 1, 3'b000, 0, 3));            // ADDI x1,x0,3
        put(enc_i(7'b0010011, 2, 3'b000, 0, 4));            // ADDI x2,x0,4
        put(enc_i(7'b0010011, 5, 3'b000, 0, 10));           // ADDI x5,x0,10
        put(enc_r(7'b1111111, 5, 3'b000, 1, 2, 7'd0));      // MAC x5,x1,x2
        put(enc_s(3'b010, 0, 5, 24));                        // SW x5,24(x0)
`ifdef CORE_MAC_EN
        expect_txn(1, 32'd24, 4'b1111, 32'd22);
`else
        expect_txn(1, 32'd24, 4'b1111, 32'd10);
`endif
        put(enc_j(0, 0));                                    // JAL x0,0

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_in_addr", in_addr, 32'h100);
        check_val("rst_read_e", {31'd0, read_e}, 32'd0);
        check_val("rst_write_e", {31'd0, write_e}, 32'd0);
        res = 1'b0;
        #1 check_val("first_fetch", in_addr, 32'h100);
        @(posedge clk);
        #1 check_val("second_fetch", in_addr, 32'h104);

        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (in_addr == 32'h140) found = 1;
        end
        if (!found) begin
            check_val("halt_window_reached", 32'd0, 32'd1);
        end else begin
            #1 halt = 1'b1;
            repeat (3) begin
                @(negedge clk);
                check_val("halt_in_addr", in_addr, 32'h140);
            end
            #1 halt = 1'b0;
        end

        for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        check_val("pending_txns", exp_q.size(), 32'd0);
        check_val("lw_read_e_cycles", lw_cycles, 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
